// File: rtl/regfile_dump.sv
// Register-file dump engine: walks every register through one read port and
// streams the words out over valid/ready. Optional trailing checksum word: REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump #(
    parameter int P_WIDTH      = 16,
    parameter int P_NUM_REGS   = 16,
    parameter int P_ADDR_WIDTH = 4
) (
    input  logic                    I_CLK,
    input  logic                    I_RESET,
    input  logic                    I_START,
    output logic                    O_BUSY,
    output logic [P_ADDR_WIDTH-1:0] O_RD_ADDR,
    input  logic [P_WIDTH-1:0]      I_RD_DATA,
    output logic [P_WIDTH-1:0]      O_DATA,
    output logic                    O_VALID,
    input  logic                    I_READY,
    output logic                    O_LAST,
    output logic                    O_DONE
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;
`endif

    localparam logic [P_ADDR_WIDTH-1:0] LAST_IDX = P_ADDR_WIDTH'(P_NUM_REGS - 1);

    state_t                  state;
    logic [P_ADDR_WIDTH-1:0] index;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [P_WIDTH-1:0]      checksum;
`endif

    // The index register doubles as the read address, so it simply holds
    // its last value whenever the engine is not fetching.
    assign O_RD_ADDR = index;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state    <= S_IDLE;
            index    <= '0;
            O_DATA   <= '0;
            O_VALID  <= 1'b0;
            O_LAST   <= 1'b0;
            O_DONE   <= 1'b0;
            O_BUSY   <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (I_START) begin
                        state    <= S_FETCH;
                        index    <= '0;
                        O_BUSY   <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    O_DATA  <= I_RD_DATA;
                    O_VALID <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    O_LAST  <= 1'b0;
`else
                    O_LAST  <= (index == LAST_IDX);
`endif
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (O_VALID && I_READY) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        checksum <= checksum + O_DATA;
`endif
                        if (index == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            // Running sum plus the word just accepted is the final checksum.
                            O_DATA  <= checksum + O_DATA;
                            O_VALID <= 1'b1;
                            O_LAST  <= 1'b1;
                            state   <= S_CSUM;
`else
                            O_VALID <= 1'b0;
                            O_LAST  <= 1'b0;
                            O_DONE  <= 1'b1;
                            state   <= S_DONE;
`endif
                        end else begin
                            O_VALID <= 1'b0;
                            O_LAST  <= 1'b0;
                            index   <= index + 1'b1;
                            state   <= S_FETCH;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (O_VALID && I_READY) begin
                        O_VALID <= 1'b0;
                        O_LAST  <= 1'b0;
                        O_DONE  <= 1'b1;
                        state   <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    O_DONE <= 1'b0;
                    O_BUSY <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: directed dumps plus randomized
// back-pressure, scored against an array/queue model of the register file.
module tb_regfile_dump;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int AW = 4;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          I_CLK = 1'b0;
    logic          I_RESET, I_START, I_READY;
    logic          O_BUSY, O_VALID, O_LAST, O_DONE;
    logic [AW-1:0] O_RD_ADDR;
    logic [W-1:0]  I_RD_DATA, O_DATA;
    logic [W-1:0]  regs [N];

    int checks = 0;
    int errors = 0;

    regfile_dump #(.P_WIDTH(W), .P_NUM_REGS(N), .P_ADDR_WIDTH(AW)) dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_START(I_START), .O_BUSY(O_BUSY),
        .O_RD_ADDR(O_RD_ADDR), .I_RD_DATA(I_RD_DATA), .O_DATA(O_DATA),
        .O_VALID(O_VALID), .I_READY(I_READY), .O_LAST(O_LAST), .O_DONE(O_DONE)
    );

    always #5 I_CLK = ~I_CLK;
    assign I_RD_DATA = regs[O_RD_ADDR];

    task automatic tick;
        @(posedge I_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_valid"}, O_VALID, 0);
        chk({pfx, "_data"},  O_DATA, 0);
        chk({pfx, "_last"},  O_LAST, 0);
        chk({pfx, "_done"},  O_DONE, 0);
        chk({pfx, "_busy"},  O_BUSY, 0);
        chk({pfx, "_addr"},  O_RD_ADDR, 0);
    endtask

    // One dump from I_START to O_DONE. stall_w: word held off for 5 cycles;
    // start_w: word during which a stray I_START is pulsed; reset_w: word in
    // whose SEND phase reset hits (dump abandoned); start_in_done: pulse
    // I_START in the DONE cycle; chk_lat: compare O_DONE timing.
    task automatic run_dump(input bit rnd, input int stall_w, input int start_w,
                            input int reset_w, input bit start_in_done, input bit chk_lat);
        logic [W-1:0] expq[$];
        logic [W-1:0] got[$];
        bit           lastq[$];
        logic [W-1:0] sum   = '0;
        logic [W-1:0] pdata = '0;
        int           cyc = 0, done_cyc = -1, stall_n = 0;
        bit           pend = 0, extra_done = 0;
        for (int i = 0; i < N; i++) begin
            expq.push_back(regs[i]);
            sum += regs[i];
        end
        if (CS != 0) expq.push_back(sum);

        chk("idle_busy", O_BUSY, 0);
        I_START = 1'b1;
        tick;
        I_START = 1'b0;
        cyc = 1;
        while (cyc < 4000) begin
            if (O_DONE) begin
                done_cyc = cyc;
                break;
            end
            chk("busy", O_BUSY, 1);
            chk("addr_range", O_RD_ADDR <= AW'(N - 1), 1);
            if (pend) begin
                chk("hold_valid", O_VALID, 1);
                chk("hold_data", O_DATA, pdata);
            end
            if (reset_w >= 0 && O_VALID && got.size() == reset_w) begin
                I_RESET = 1'b1;
                I_READY = 1'b0;
                tick;
                I_RESET = 1'b0;
                chk_zero("midrst");
                tick;
                chk("midrst_no_resume", O_BUSY, 0);
                return;
            end
            I_START = (start_w >= 0 && O_VALID && got.size() == start_w && !extra_done);
            if (I_START) extra_done = 1;
            if (O_VALID && got.size() == stall_w && stall_n < 5) begin
                I_READY = 1'b0;
                stall_n++;
            end else begin
                I_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (O_VALID && I_READY) begin
                got.push_back(O_DATA);
                lastq.push_back(O_LAST);
                pend = 0;
            end else begin
                pend  = O_VALID;
                pdata = O_DATA;
            end
            tick;
            cyc++;
        end

        I_START = start_in_done;
        chk("done_seen", done_cyc > 0, 1);
        if (chk_lat) chk("done_latency", done_cyc, 2 * N + 1 + CS);
        chk("done_last_low", O_LAST, 0);
        chk("done_valid_low", O_VALID, 0);
        chk("done_busy", O_BUSY, 1);
        chk("word_count", got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            chk($sformatf("word%0d", i), got[i], expq[i]);
            chk($sformatf("last%0d", i), lastq[i], (i == expq.size() - 1));
        end
        tick;
        I_START = 1'b0;
        chk("done_pulse", O_DONE, 0);
        chk("busy_after", O_BUSY, 0);
        if (start_in_done) begin
            tick;
            chk("start_in_done_ignored", O_BUSY, 0);
        end
    endtask

    initial begin
        I_RESET = 1'b1;
        I_START = 1'b0;
        I_READY = 1'b0;
        for (int i = 0; i < N; i++) regs[i] = 16'h1000 + W'(i);
        tick;
        tick;
        chk_zero("reset");
        I_RESET = 1'b0;
        tick;

        // In-order dump with the sink always ready
        run_dump(0, -1, -1, -1, 0, 1);
        // Back-pressure on word 3
        run_dump(0, 3, -1, -1, 0, 0);
        // Stray I_START mid-dump and in the DONE cycle
        run_dump(0, -1, 7, -1, 1, 1);
        // Reset during word 9, then a fresh dump from the beginning
        run_dump(0, -1, -1, 9, 0, 0);
        run_dump(0, -1, -1, -1, 0, 1);
        // Random contents, random back-pressure, back-to-back dumps
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) regs[i] = W'($urandom);
            run_dump(1, -1, -1, -1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
